// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the boot loader.
// The master view belongs to the loader; the slave view is the surrounding
// byte source and memory write port.
interface instr_mem_loader_if;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic [31:0] write_addr_o;
   logic [31:0] write_data_o;
   logic        write_enable_o;

   modport master (
      input  byte_valid_i,
      input  byte_data_i,
      output byte_ready_o,
      output write_addr_o,
      output write_data_o,
      output write_enable_o
   );

   modport slave (
      output byte_valid_i,
      output byte_data_i,
      input  byte_ready_o,
      input  write_addr_o,
      input  write_data_o,
      input  write_enable_o
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader. Receives a frame made of a
// little-endian 32-bit word count followed by the payload bytes, writes the
// payload as little-endian words at incrementing addresses from BASE_ADDR,
// and keeps the CPU core in reset until the last word has been written.
module instr_mem_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 16384,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   instr_mem_loader_if.master bus,
   output logic               core_rst_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o
);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // Last idle-count value before the timeout fires; meaningless when disabled.
   localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);
   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [23:0] asm_buf;   // lower three bytes of the length or data word being assembled
   logic [31:0] length;
   logic [31:0] word_cnt;
   logic [31:0] to_cnt;

   logic        accept;
   logic [31:0] full_word;
   logic        to_active;
   logic        to_hit;
   logic        bad_len;

   // Handshake decode, word completion and timeout/length qualifiers.
   always_comb begin
      accept    = bus.byte_valid_i && bus.byte_ready_o;
      full_word = {bus.byte_data_i, asm_buf};
      to_active = (state == S_DATA) || ((state == S_LEN) && (byte_cnt != 2'd0));
      to_hit    = TO_EN && (to_cnt == TO_LAST);
      bad_len   = (full_word == 32'd0) || (full_word > MAX_LEN);
   end

   // Loader FSM with registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= S_LEN;
         byte_cnt           <= 2'd0;
         asm_buf            <= 24'd0;
         length             <= 32'd0;
         word_cnt           <= 32'd0;
         to_cnt             <= 32'd0;
         bus.byte_ready_o   <= 1'b1;
         bus.write_enable_o <= 1'b0;
         bus.write_addr_o   <= BASE_ADDR;
         bus.write_data_o   <= 32'd0;
         core_rst_o         <= 1'b1;
         busy_o             <= 1'b0;
         done_o             <= 1'b0;
         error_o            <= 1'b0;
      end else begin
         bus.write_enable_o <= 1'b0;
         case (state)
            S_LEN, S_DATA: begin
               if (accept) begin
                  // An accepted byte always beats a simultaneous timeout.
                  to_cnt   <= 32'd0;
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_buf  <= {bus.byte_data_i, asm_buf[23:8]};
                  if (state == S_LEN) begin
                     busy_o <= 1'b1;
                     if (byte_cnt == 2'd3) begin
                        if (bad_len) begin
                           state            <= S_ERR;
                           error_o          <= 1'b1;
                           busy_o           <= 1'b0;
                           bus.byte_ready_o <= 1'b0;
                        end else begin
                           length   <= full_word;
                           word_cnt <= 32'd0;
                           state    <= S_DATA;
                        end
                     end
                  end else if (byte_cnt == 2'd3) begin
                     state              <= S_WRITE;
                     bus.byte_ready_o   <= 1'b0;
                     bus.write_enable_o <= 1'b1;
                     bus.write_data_o   <= full_word;
                     bus.write_addr_o   <= BASE_ADDR + (word_cnt << 2);
                  end
               end else if (to_active && TO_EN) begin
                  if (to_hit) begin
                     state            <= S_ERR;
                     error_o          <= 1'b1;
                     busy_o           <= 1'b0;
                     bus.byte_ready_o <= 1'b0;
                  end else begin
                     to_cnt <= to_cnt + 32'd1;
                  end
               end
            end

            S_WRITE: begin
               word_cnt <= word_cnt + 32'd1;
               if ((word_cnt + 32'd1) == length) begin
                  state      <= S_DONE;
                  core_rst_o <= 1'b0;
                  done_o     <= 1'b1;
                  busy_o     <= 1'b0;
               end else begin
                  state            <= S_DATA;
                  bus.byte_ready_o <= 1'b1;
               end
            end

            S_DONE, S_ERR: begin
               if (start_i) begin
                  state            <= S_LEN;
                  core_rst_o       <= 1'b1;
                  done_o           <= 1'b0;
                  error_o          <= 1'b0;
                  busy_o           <= 1'b0;
                  byte_cnt         <= 2'd0;
                  word_cnt         <= 32'd0;
                  to_cnt           <= 32'd0;
                  asm_buf          <= 24'd0;
                  bus.byte_ready_o <= 1'b1;
               end
            end

            default: begin
               state <= S_LEN;
            end
         endcase
      end
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Boot-time controller that owns the write port of the read/write instruction memory.
- Accepts a byte stream (UART receiver or debug bridge) framed as a little-endian 32-bit word count followed by payload bytes.
- Assembles the payload into little-endian words and issues one write per word at incrementing word addresses.
- Holds the core in reset for the whole load and releases it only after the last write commits.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.
- MAX_WORDS, 16384, largest accepted word count (64 KiB / 4).
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes once a frame has started; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  re-arm request; honoured only in DONE or ERR.
- byte_valid_i  in  1  byte source has data.
- byte_data_i  in  8  byte value.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- write_addr_o  out  32  instruction-memory write byte address.
- write_data_o  out  32  instruction-memory write data.
- write_enable_o  out  1  one-cycle write strobe.
- core_rst_o  out  1  reset to the CPU core.
- busy_o  out  1  frame in progress.
- done_o  out  1  load completed successfully.
- error_o  out  1  frame rejected or timed out.

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates on posedge clk_i.
  - rst_i is synchronous and active-high.
- Reset values
  - State is LEN.
  - byte_ready_o=1, write_enable_o=0, write_addr_o=BASE_ADDR, write_data_o=0.
  - core_rst_o=1, busy_o=0, done_o=0, error_o=0.
  - Byte counter, word counter and timeout counter are all 0.
- Byte handshake
  - A byte is accepted when byte_valid_i && byte_ready_o at the clock edge.
  - byte_ready_o=1 only in LEN and DATA.
- State LEN
  - Collects 4 bytes into the length register; the first byte is bits [7:0].
  - busy_o goes 1 from the first accepted byte.
  - After the 4th byte:
    - length==0 or length>MAX_WORDS -> ERR.
    - otherwise -> DATA, with word counter=0.
- State DATA
  - Collects 4 bytes into a word; the first byte lands in data[7:0].
  - After the 4th byte -> WRITE.
- State WRITE (exactly one cycle)
  - write_enable_o=1.
  - write_data_o = assembled word.
  - write_addr_o = BASE_ADDR + 4*word_counter.
  - byte_ready_o=0.
  - Word counter then increments.
  - If the incremented count equals length -> DONE, else -> DATA.
- Latency
  - The write strobe occurs in the cycle immediately after the cycle in which the 4th byte of the word is accepted.
  - Minimum spacing between writes is 5 cycles.
- write_addr_o and write_data_o hold their last values outside WRITE; only write_enable_o qualifies them.
- State DONE
  - core_rst_o=0, done_o=1, busy_o=0, byte_ready_o=0.
  - Incoming bytes are not accepted (backpressured).
- State ERR
  - error_o=1, core_rst_o=1, busy_o=0, byte_ready_o=0.
  - Memory contents are left as partially written.
- Re-arm
  - start_i=1 in DONE or ERR -> LEN on the next edge.
  - On that transition: core_rst_o=1, done_o=0, error_o=0, all counters cleared.
  - start_i is ignored in LEN, DATA and WRITE.
- Timeout
  - Applies in LEN with byte counter != 0, and in DATA.
  - The counter increments on every cycle in which no byte is accepted and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - Never active in LEN before the first byte, so the loader waits indefinitely for a frame to start.
- Address arithmetic
  - Computed with the word counter in 32 bits; no wrap is possible because length <= MAX_WORDS.
- Reset mid-operation
  - rst_i in any state returns everything to reset values on that edge.
  - The core is held in reset and no write strobe is issued in the reset cycle.
  - A partially received word or length is discarded.
- Simultaneous events
  - rst_i has priority over everything.
  - If the timeout terminal count and an accepted byte fall in the same cycle, the byte wins and the timeout counter clears.

Test Plan:
- Basic load: after reset, stream 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 with valid held high.
  - Expect write 0x00000013 @0x0 and write 0x0000006F @0x4, each one cycle after its 4th byte.
  - Expect core_rst_o to fall and done_o to rise in the cycle after the second write.
- Backpressure/gaps: same frame with byte_valid_i toggled randomly.
  - Expect identical writes.
  - Expect byte_ready_o=0 exactly during each WRITE cycle; no byte lost or duplicated.
- Bad length: stream 00 00 00 00.
  - Expect ERR: error_o=1, no write strobe, core_rst_o=1.
  - Repeat with length 0x4001 (MAX_WORDS+1) -> same result.
- Timeout: with TIMEOUT_CYCLES=16, send length 1 plus 2 payload bytes, then idle.
  - Expect error_o=1 after 16 idle cycles and no write.
  - Then start_i=1 followed by a valid frame -> normal load.
- Reset mid-frame: send length 3 and 6 payload bytes, assert rst_i for one cycle, then send a full length-1 frame with word 0xDEADBEEF.
  - Expect only the writes completed before reset plus 0xDEADBEEF @BASE_ADDR after reset.
- DONE behaviour: after a completed load, drive bytes.
  - Expect byte_ready_o=0 and no writes.
  - Assert start_i -> core_rst_o=1, done_o=0, and a second load proceeds normally.
